// File: rtl/ring_step_driver.sv
// ring_step_driver
// ----------------
// Initiator for a one-hot 3-state ring counter. A command names the ring
// state to reach (001, 010 or 100). The driver keeps its own copy of the ring
// state and emits single-cycle advance pulses on x_out until that copy equals
// the target. Callers can then address ring states directly instead of
// counting pulses.
//
// Parameters
//   GAP_CYCLES  idle cycles (x_out low) inserted after every pulse, 0..15
//   CNT_W       width of the lifetime pulse counter (wraps silently)
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    command accepted this cycle if valid (high only when idle)
//   cmd_target   target ring state, must be one-hot
//   x_out        advance pulse to the ring counter's x_in (registered)
//   model_state  driver's copy of the ring state (one-hot)
//   busy         high whenever a command is in progress
//   done         one-cycle pulse when a command completes
//   err          one-cycle pulse when a command is rejected (target not one-hot)
//   pulse_count  number of pulses issued since reset
//
// Optional build macro RING_SYNC_CHECK_EN adds:
//   ring_state   state output of the ring counter
//   sync_err     sticky flag: ring_state differed from model_state at
//                completion; cleared by the next accepted command or reset

module ring_step_driver #(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_target,
  output logic             x_out,
  output logic [2:0]       model_state,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] pulse_count
`ifdef RING_SYNC_CHECK_EN
  ,
  input  logic [2:0]       ring_state,
  output logic             sync_err
`endif
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PULSE = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic [2:0]       state_reg, state_next;
  logic [1:0]       steps_reg, steps_next;
  logic [3:0]       gap_cnt_reg, gap_cnt_next;
  logic [2:0]       model_reg, model_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             x_out_reg, done_reg, err_reg;

  // One and two rotations of the current model state (001->010->100->001).
  logic [2:0] rot1, rot2;
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rot
      assign rot1[gi] = model_reg[(gi + 2) % 3];
      assign rot2[gi] = model_reg[(gi + 1) % 3];
    end
  endgenerate

  logic target_one_hot;
  assign target_one_hot = (cmd_target == 3'b001) || (cmd_target == 3'b010) ||
                          (cmd_target == 3'b100);

  logic [1:0] steps_after_pulse;
  assign steps_after_pulse = steps_reg - 2'd1;

  always_comb begin
    state_next   = state_reg;
    steps_next   = steps_reg;
    gap_cnt_next = gap_cnt_reg;
    model_next   = model_reg;
    count_next   = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (!target_one_hot) begin
            state_next = ST_ERR;
          end else if (cmd_target == model_reg) begin
            state_next = ST_DONE;
          end else begin
            // Target is one or two forward rotations away.
            steps_next = (cmd_target == rot1) ? 2'd1 : 2'd2;
            state_next = ST_PULSE;
          end
        end
      end
      ST_PULSE: begin
        // The ring counter samples x_out=1 on this same edge, so the model
        // advances in lockstep with it.
        model_next = rot1;
        count_next = count_reg + CNT_W'(1);
        steps_next = steps_after_pulse;
        if (GAP_CYCLES > 0) begin
          gap_cnt_next = GAP_LOAD;
          state_next   = ST_GAP;
        end else if (steps_after_pulse != 2'd0) begin
          state_next = ST_PULSE;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == 4'd0) begin
          state_next = (steps_reg != 2'd0) ? ST_PULSE : ST_DONE;
        end else begin
          gap_cnt_next = gap_cnt_reg - 4'd1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      steps_reg   <= 2'd0;
      gap_cnt_reg <= 4'd0;
      model_reg   <= 3'b001;
      count_reg   <= '0;
      x_out_reg   <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      steps_reg   <= steps_next;
      gap_cnt_reg <= gap_cnt_next;
      model_reg   <= model_next;
      count_reg   <= count_next;
      // Output flags are registered from the next-state decode so they line
      // up exactly with the state they describe.
      x_out_reg   <= (state_next == ST_PULSE);
      done_reg    <= (state_next == ST_DONE);
      err_reg     <= (state_next == ST_ERR);
    end
  end

`ifdef RING_SYNC_CHECK_EN
  logic sync_err_reg, sync_err_next;

  always_comb begin
    sync_err_next = sync_err_reg;
    if (state_reg == ST_IDLE && cmd_valid) begin
      sync_err_next = 1'b0;
    end else if (state_reg == ST_DONE && ring_state != model_reg) begin
      sync_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_err_reg <= 1'b0;
    end else begin
      sync_err_reg <= sync_err_next;
    end
  end

  assign sync_err = sync_err_reg;
`endif

  assign cmd_ready   = (state_reg == ST_IDLE);
  assign busy        = (state_reg != ST_IDLE);
  assign x_out       = x_out_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign model_state = model_reg;
  assign pulse_count = count_reg;

endmodule

// File: tb/tb_ring_step_driver.sv
// Testbench for ring_step_driver (default build, GAP_CYCLES=2, CNT_W=8).
// A transaction-level model turns each accepted command into a per-cycle
// schedule of expected {x_out, done, err}; a compare process checks every
// output on every falling edge. Directed commands pin the model with literal
// waveforms, then randomized traffic runs, then a mid-command reset.

module tb_ring_step_driver;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_target = 3'b000;
  logic       x_out;
  logic [2:0] model_state;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] pulse_count;

  ring_step_driver #(.GAP_CYCLES(GAP), .CNT_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .x_out       (x_out),
    .model_state (model_state),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .pulse_count (pulse_count)
  );

  always #5 clk = ~clk;

  // Stand-in ring counter driven by x_out.
  logic [2:0] ring_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ring_reg <= 3'b001;
    else if (x_out) ring_reg <= {ring_reg[1:0], ring_reg[2]};
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // sched holds one entry per future cycle: bit2 = x_out, bit1 = done, bit0 = err.
  // sched[0] describes the current cycle; an empty queue means idle.
  logic [2:0] sched[$];
  int         pos = 0;        // ring position 0,1,2 <-> 001,010,100
  int         cnt = 0;
  logic       exp_x = 0, exp_d = 0, exp_e = 0, exp_busy = 0;
  logic [2:0] exp_ms = 3'b001;
  logic [7:0] exp_cnt = 0;

  initial begin
    logic [2:0] cur;
    int tpos, steps;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        sched.delete();
        pos = 0;
        cnt = 0;
      end else if (sched.size() != 0) begin
        cur = sched.pop_front();
        if (cur[2]) begin
          pos = (pos + 1) % 3;
          cnt++;
        end
      end else if (cmd_valid) begin
        if (!(cmd_target == 3'b001 || cmd_target == 3'b010 || cmd_target == 3'b100)) begin
          sched.push_back(3'b001);
          $display("cmd target=%b rejected", cmd_target);
        end else begin
          tpos  = (cmd_target == 3'b001) ? 0 : (cmd_target == 3'b010) ? 1 : 2;
          steps = (tpos - pos + 3) % 3;
          for (int i = 0; i < steps; i++) begin
            sched.push_back(3'b100);
            for (int g = 0; g < GAP; g++) sched.push_back(3'b000);
          end
          sched.push_back(3'b010);
          $display("cmd target=%b steps=%0d", cmd_target, steps);
        end
      end
      cur      = (sched.size() != 0) ? sched[0] : 3'b000;
      exp_x    = cur[2];
      exp_d    = cur[1];
      exp_e    = cur[0];
      exp_busy = (sched.size() != 0);
      exp_ms   = 3'(1 << pos);
      exp_cnt  = 8'(cnt);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("x_out",       32'(x_out),       32'(exp_x));
      check("done",        32'(done),        32'(exp_d));
      check("err",         32'(err),         32'(exp_e));
      check("busy",        32'(busy),        32'(exp_busy));
      check("cmd_ready",   32'(cmd_ready),   32'(!exp_busy));
      check("model_state", 32'(model_state), 32'(exp_ms));
      check("ring_vs_model", 32'(ring_reg),  32'(exp_ms));
      check("pulse_count", 32'(pulse_count), 32'(exp_cnt));
      check("done_err_excl", 32'(done & err), 32'd0);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic send(input logic [2:0] t);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_target = t;
    @(posedge clk);
  endtask

  // Samples n cycles after the accepting edge; first sample is cycle k+1 (MSB first).
  task automatic capture(input int n, output logic [15:0] xs, output logic [15:0] ds,
                         output logic [15:0] es, output logic [15:0] rs);
    xs = 0; ds = 0; es = 0; rs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      xs = {xs[14:0], x_out};
      ds = {ds[14:0], done};
      es = {es[14:0], err};
      rs = {rs[14:0], cmd_ready};
    end
  endtask

  initial begin
    logic [15:0] xs, ds, es, rs;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    check("reset_model", 32'(model_state), 32'b001);
    reset_n = 1'b1;

    // 001 -> 010: one pulse, done four cycles after acceptance
    send(3'b010);
    capture(5, xs, ds, es, rs);
    check("t1_x_wave",    32'(xs), 32'b10000);
    check("t1_done_wave", 32'(ds), 32'b00010);
    check("t1_model",     32'(model_state), 32'b010);
    check("t1_count",     32'(pulse_count), 32'd1);

    // 010 -> 001: two pulses three cycles apart
    send(3'b001);
    capture(8, xs, ds, es, rs);
    check("t2_x_wave",    32'(xs), 32'b10010000);
    check("t2_done_wave", 32'(ds), 32'b00000010);
    check("t2_model",     32'(model_state), 32'b001);
    check("t2_count",     32'(pulse_count), 32'd3);

    // Zero-step command
    send(3'b001);
    capture(3, xs, ds, es, rs);
    check("t3_x_wave",    32'(xs), 32'b000);
    check("t3_done_wave", 32'(ds), 32'b100);
    check("t3_count",     32'(pulse_count), 32'd3);

    // Non-one-hot target
    send(3'b011);
    capture(3, xs, ds, es, rs);
    check("t4_err_wave",   32'(es), 32'b100);
    check("t4_x_wave",     32'(xs), 32'b000);
    check("t4_done_wave",  32'(ds), 32'b000);
    check("t4_ready_wave", 32'(rs), 32'b011);
    check("t4_model",      32'(model_state), 32'b001);

    // Randomized traffic; valid is also driven while busy and must be ignored.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      cmd_valid  = ($urandom_range(0, 2) != 0);
      cmd_target = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                               : 3'(1 << $urandom_range(0, 2));
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Two-step command aborted by reset during its first gap
    send(3'(1 << ((pos + 2) % 3)));
    @(negedge clk);            // cycle k+1: pulse
    cmd_valid = 1'b0;
    @(posedge clk);            // now in the gap
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_x_out", 32'(x_out), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_model", 32'(model_state), 32'b001);
    check("rst_ring",  32'(ring_reg), 32'b001);
    check("rst_count", 32'(pulse_count), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    capture(6, xs, ds, es, rs);
    check("rst_no_done", 32'(ds), 32'd0);
    check("rst_no_x",    32'(xs), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
